// File: rtl/vscale_hasti_arbiter_if.sv
// HASTI (AHB-Lite) bus bundle: one master-side request set plus the slave response.
// The master modport drives the request; the slave modport answers it.
interface vscale_hasti_arbiter_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/vscale_hasti_arbiter.sv
// Two-master (imem/dmem) to one-slave HASTI arbiter: dmem priority, bounded imem starvation,
// one-deep address hold per master so address-phase acceptance never stalls.
module vscale_hasti_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    vscale_hasti_arbiter_if.slave  imem,
    vscale_hasti_arbiter_if.slave  dmem,
    vscale_hasti_arbiter_if.master mem
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] LIMIT         = 3'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DMEM = 2'd2
    } owner_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic        mastlock;
        logic [3:0]  prot;
    } req_t;

    // Index 0 is imem, index 1 is dmem throughout.
    owner_e      downer_q, downer_d, sel_q, sel;
    logic        lock_q, lock_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic [1:0]  hold_valid_q, hold_valid_d;
    req_t        hold_q [2];
    req_t        hold_d [2];
    logic [2:0]  starve_cnt_q, starve_cnt_d;

    req_t        live [2];
    req_t        src;
    logic [1:0]  owns, hready, live_req, req, issue;

    assign live[0] = {imem.haddr, imem.hwrite, imem.hsize, imem.hburst, imem.hmastlock, imem.hprot};
    assign live[1] = {dmem.haddr, dmem.hwrite, dmem.hsize, dmem.hburst, dmem.hmastlock, dmem.hprot};

    assign owns[0]     = (downer_q == OWN_IMEM);
    assign owns[1]     = (downer_q == OWN_DMEM);
    assign hready      = ~outstanding_q | (owns & {2{mem.hready}});
    assign live_req[0] = hready[0] & (imem.htrans == HTRANS_NONSEQ);
    assign live_req[1] = hready[1] & (dmem.htrans == HTRANS_NONSEQ);
    assign req         = hold_valid_q | live_req;

    always_comb begin
        sel = OWN_NONE;
        if (lock_q) begin
            sel = sel_q;
        end else if (req[0] && (starve_cnt_q == LIMIT)) begin
            sel = OWN_IMEM;
        end else if (req[1]) begin
            sel = OWN_DMEM;
        end else if (req[0]) begin
            sel = OWN_IMEM;
        end
    end

    assign issue[0] = (sel == OWN_IMEM) & mem.hready;
    assign issue[1] = (sel == OWN_DMEM) & mem.hready;

    // A held copy always wins over the live bus for the same master.
    always_comb begin
        src = '0;
        case (sel)
            OWN_IMEM: src = hold_valid_q[0] ? hold_q[0] : live[0];
            OWN_DMEM: src = hold_valid_q[1] ? hold_q[1] : live[1];
            default:  src = '0;
        endcase
    end

    assign mem.haddr     = src.addr;
    assign mem.hwrite    = src.write;
    assign mem.hsize     = src.size;
    assign mem.hburst    = src.burst;
    assign mem.hmastlock = src.mastlock;
    assign mem.hprot     = src.prot;
    assign mem.htrans    = (sel == OWN_NONE) ? HTRANS_IDLE : HTRANS_NONSEQ;

    always_comb begin
        mem.hwdata = '0;
        case (downer_q)
            OWN_IMEM: mem.hwdata = imem.hwdata;
            OWN_DMEM: mem.hwdata = dmem.hwdata;
            default:  mem.hwdata = '0;
        endcase
    end

    assign imem.hrdata = mem.hrdata;
    assign dmem.hrdata = mem.hrdata;
    assign imem.hready = hready[0];
    assign dmem.hready = hready[1];
    assign imem.hresp  = owns[0] & mem.hresp;
    assign dmem.hresp  = owns[1] & mem.hresp;

    always_comb begin
        outstanding_d = outstanding_q;
        hold_valid_d  = hold_valid_q;
        hold_d        = hold_q;
        starve_cnt_d  = starve_cnt_q;
        downer_d      = downer_q;
        lock_d        = (sel != OWN_NONE) && !mem.hready;
        if (mem.hready) begin
            downer_d = sel;
        end
        for (int m = 0; m < 2; m++) begin
            outstanding_d[m] = (outstanding_q[m] & ~(owns[m] & mem.hready)) | live_req[m];
            hold_valid_d[m]  = (hold_valid_q[m] | live_req[m]) & ~issue[m];
            if (live_req[m] && !issue[m]) begin
                hold_d[m] = live[m];
            end
        end
        if (issue[0] || !(req[0] || outstanding_q[0])) begin
            starve_cnt_d = '0;
        end else if (issue[1] && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            downer_q      <= OWN_NONE;
            sel_q         <= OWN_NONE;
            lock_q        <= 1'b0;
            outstanding_q <= '0;
            hold_valid_q  <= '0;
            hold_q[0]     <= '0;
            hold_q[1]     <= '0;
            starve_cnt_q  <= '0;
        end else begin
            downer_q      <= downer_d;
            sel_q         <= sel;
            lock_q        <= lock_d;
            outstanding_q <= outstanding_d;
            hold_valid_q  <= hold_valid_d;
            hold_q[0]     <= hold_d[0];
            hold_q[1]     <= hold_d[1];
            starve_cnt_q  <= starve_cnt_d;
        end
    end
endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// Bench for vscale_hasti_arbiter: directed vector table, hand-written corner sequences,
// then random traffic checked against a transaction-level reference model.
module tb_vscale_hasti_arbiter;
    localparam int LIMIT = 4;
    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    vscale_hasti_arbiter_if imem_bus ();
    vscale_hasti_arbiter_if dmem_bus ();
    vscale_hasti_arbiter_if mem_bus ();

    vscale_hasti_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .imem  (imem_bus),
        .dmem  (dmem_bus),
        .mem   (mem_bus)
    );

    typedef struct packed {
        logic [1:0]  tr;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  sz;
        logic [2:0]  bu;
        logic        ml;
        logic [3:0]  pr;
    } mreq_t;

    typedef struct {
        logic [1:0]  i_tr;
        logic [31:0] i_addr;
        logic [1:0]  d_tr;
        logic [31:0] d_addr;
        logic        d_wr;
        logic [31:0] d_wd;
        logic        mh;
        logic        mr;
        logic [1:0]  e_tr;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_ir;
        logic        e_dr;
        logic        e_iresp;
        logic        e_dresp;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_m(input int m, input mreq_t r, input logic [31:0] wd);
        if (m == 0) begin
            imem_bus.htrans = r.tr;    imem_bus.haddr = r.addr;  imem_bus.hwrite = r.wr;
            imem_bus.hsize = r.sz;     imem_bus.hburst = r.bu;   imem_bus.hmastlock = r.ml;
            imem_bus.hprot = r.pr;     imem_bus.hwdata = wd;
        end else begin
            dmem_bus.htrans = r.tr;    dmem_bus.haddr = r.addr;  dmem_bus.hwrite = r.wr;
            dmem_bus.hsize = r.sz;     dmem_bus.hburst = r.bu;   dmem_bus.hmastlock = r.ml;
            dmem_bus.hprot = r.pr;     dmem_bus.hwdata = wd;
        end
    endtask

    function automatic mreq_t simple(input logic [1:0] tr, input logic [31:0] a, input logic w);
        mreq_t r;
        r = '0;
        r.tr = tr;
        r.addr = a;
        r.wr = w;
        return r;
    endfunction

    task automatic drive_slave(input logic h, input logic r, input logic [31:0] rd);
        mem_bus.hready = h;
        mem_bus.hresp  = r;
        mem_bus.hrdata = rd;
    endtask

    // Reference model: per-master "accepted, not yet done" flag, pending held request,
    // current data-phase owner (-1 none), address-phase selection frozen by a stall.
    bit          busy [2];
    bit          pend_v [2];
    mreq_t       pend [2];
    int          dp;
    int          frozen;
    int          starve;
    logic [31:0] wdat [2];
    mreq_t       cur [2];
    bit          stay [2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            busy[m] = 0; pend_v[m] = 0; stay[m] = 0; wdat[m] = '0; cur[m] = '0;
        end
        dp = -1;
        frozen = -1;
        starve = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_m(0, '0, '0);
        drive_m(1, '0, '0);
        drive_slave(1'b1, 1'b0, '0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          i_tr    i_addr     d_tr    d_addr      wr    d_wd          mh    mr    e_tr    e_addr      e_wd          ir    dr    iresp dresp
        tbl[0] = '{IDLE,   32'h0,     IDLE,   32'h0,      1'b0, 32'h0,        1'b1, 1'b0, IDLE,   32'h0,      32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{NONSEQ, 32'h200,   IDLE,   32'h0,      1'b0, 32'h0,        1'b1, 1'b0, NONSEQ, 32'h200,    32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{IDLE,   32'h0,     IDLE,   32'h0,      1'b0, 32'h0,        1'b1, 1'b0, IDLE,   32'h0,      32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{NONSEQ, 32'h204,   NONSEQ, 32'h1000,   1'b1, 32'h0,        1'b1, 1'b0, NONSEQ, 32'h1000,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{NONSEQ, 32'h204,   IDLE,   32'h0,      1'b0, 32'hDEADBEEF, 1'b1, 1'b0, NONSEQ, 32'h204,    32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{IDLE,   32'h0,     IDLE,   32'h0,      1'b0, 32'h0,        1'b1, 1'b0, IDLE,   32'h0,      32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{IDLE,   32'h0,     NONSEQ, 32'h2000,   1'b0, 32'h0,        1'b1, 1'b0, NONSEQ, 32'h2000,   32'h0,        1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{IDLE,   32'h0,     IDLE,   32'h0,      1'b0, 32'h0,        1'b0, 1'b1, IDLE,   32'h0,      32'h0,        1'b1, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{IDLE,   32'h0,     IDLE,   32'h0,      1'b0, 32'h0,        1'b1, 1'b1, IDLE,   32'h0,      32'h0,        1'b1, 1'b1, 1'b0, 1'b1};
        tbl[9] = '{IDLE,   32'h0,     IDLE,   32'h0,      1'b0, 32'h0,        1'b1, 1'b0, IDLE,   32'h0,      32'h0,        1'b1, 1'b1, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_m(0, simple(tbl[i].i_tr, tbl[i].i_addr, 1'b0), '0);
            drive_m(1, simple(tbl[i].d_tr, tbl[i].d_addr, tbl[i].d_wr), tbl[i].d_wd);
            drive_slave(tbl[i].mh, tbl[i].mr, 32'hA500_0000 + 32'(i));
            @(negedge clk);
            chk($sformatf("tbl%0d htrans", i), 64'(mem_bus.htrans), 64'(tbl[i].e_tr));
            chk($sformatf("tbl%0d haddr", i), 64'(mem_bus.haddr), 64'(tbl[i].e_addr));
            chk($sformatf("tbl%0d hwdata", i), 64'(mem_bus.hwdata), 64'(tbl[i].e_wd));
            chk($sformatf("tbl%0d imem_hready", i), 64'(imem_bus.hready), 64'(tbl[i].e_ir));
            chk($sformatf("tbl%0d dmem_hready", i), 64'(dmem_bus.hready), 64'(tbl[i].e_dr));
            chk($sformatf("tbl%0d imem_hresp", i), 64'(imem_bus.hresp), 64'(tbl[i].e_iresp));
            chk($sformatf("tbl%0d dmem_hresp", i), 64'(dmem_bus.hresp), 64'(tbl[i].e_dresp));
            chk($sformatf("tbl%0d imem_hrdata", i), 64'(imem_bus.hrdata), 64'(32'hA500_0000 + 32'(i)));
            next_cycle();
        end

        // Slave wait states during a dmem data phase with imem held.
        drive_m(0, simple(NONSEQ, 32'h300, 1'b0), '0);
        drive_m(1, simple(NONSEQ, 32'h3000, 1'b0), '0);
        drive_slave(1'b1, 1'b0, '0);
        @(negedge clk);
        chk("ws issue dmem haddr", 64'(mem_bus.haddr), 64'(32'h3000));
        next_cycle();
        drive_m(1, '0, '0);
        for (int k = 0; k < 3; k++) begin
            drive_slave(1'b0, 1'b0, '0);
            @(negedge clk);
            chk($sformatf("ws%0d haddr", k), 64'(mem_bus.haddr), 64'(32'h300));
            chk($sformatf("ws%0d htrans", k), 64'(mem_bus.htrans), 64'(NONSEQ));
            chk($sformatf("ws%0d dmem_hready", k), 64'(dmem_bus.hready), 64'(0));
            chk($sformatf("ws%0d imem_hready", k), 64'(imem_bus.hready), 64'(0));
            next_cycle();
        end
        drive_slave(1'b1, 1'b0, '0);
        @(negedge clk);
        chk("ws release haddr", 64'(mem_bus.haddr), 64'(32'h300));
        chk("ws release dmem_hready", 64'(dmem_bus.hready), 64'(1));
        chk("ws release imem_hready", 64'(imem_bus.hready), 64'(0));
        next_cycle();
        drive_m(0, '0, '0);
        @(negedge clk);
        chk("ws imem done hready", 64'(imem_bus.hready), 64'(1));
        chk("ws idle htrans", 64'(mem_bus.htrans), 64'(IDLE));
        next_cycle();

        // Reset while imem is held and dmem is in its data phase.
        drive_m(0, simple(NONSEQ, 32'h500, 1'b0), '0);
        drive_m(1, simple(NONSEQ, 32'h5000, 1'b1), '0);
        next_cycle();
        drive_m(1, '0, 32'h1234_5678);
        drive_slave(1'b0, 1'b0, '0);
        @(negedge clk);
        chk("rst pre starve_cnt", 64'(dut.starve_cnt_q), 64'(1));
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        drive_m(0, '0, '0);
        drive_m(1, '0, '0);
        drive_slave(1'b1, 1'b1, '0);
        @(negedge clk);
        chk("rst htrans", 64'(mem_bus.htrans), 64'(IDLE));
        chk("rst imem_hready", 64'(imem_bus.hready), 64'(1));
        chk("rst dmem_hready", 64'(dmem_bus.hready), 64'(1));
        chk("rst dmem_hresp", 64'(dmem_bus.hresp), 64'(0));
        chk("rst starve_cnt", 64'(dut.starve_cnt_q), 64'(0));
        next_cycle();

        // Starvation bound: both masters always requesting.
        do_reset();
        begin
            logic [31:0] a_i, a_d;
            a_i = 32'h4000;
            a_d = 32'h8000;
            for (int k = 0; k < 15; k++) begin
                drive_m(0, simple(NONSEQ, a_i, 1'b0), '0);
                drive_m(1, simple(NONSEQ, a_d, 1'b0), '0);
                drive_slave(1'b1, 1'b0, '0);
                @(negedge clk);
                chk($sformatf("starve order %0d is_dmem", k), 64'(mem_bus.haddr[15]), 64'((k % (LIMIT + 1)) != LIMIT));
                if (imem_bus.hready) a_i += 4;
                if (dmem_bus.hready) a_d += 4;
                next_cycle();
            end
        end

        // Random traffic against the reference model.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit    rdy [2];
            bit    live [2];
            bit    cand [2];
            int    choice;
            bit    mh;
            mreq_t src;

            reset = ($urandom_range(0, 99) == 0);
            for (int m = 0; m < 2; m++) begin
                if (!stay[m]) begin
                    cur[m].tr   = $urandom_range(0, 1) ? NONSEQ : IDLE;
                    cur[m].addr = $urandom;
                    cur[m].wr   = 1'($urandom);
                    cur[m].sz   = 3'($urandom);
                    cur[m].bu   = 3'($urandom);
                    cur[m].ml   = 1'($urandom);
                    cur[m].pr   = 4'($urandom);
                end
                drive_m(m, cur[m], wdat[m]);
            end
            mh = ($urandom_range(0, 3) != 0);
            drive_slave(mh, ($urandom_range(0, 7) == 0), $urandom);

            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                rdy[m]  = !busy[m] || (dp == m && mh);
                live[m] = rdy[m] && (cur[m].tr == NONSEQ);
                cand[m] = pend_v[m] || live[m];
            end
            if (frozen >= 0)                    choice = frozen;
            else if (cand[0] && starve == LIMIT) choice = 0;
            else if (cand[1])                   choice = 1;
            else if (cand[0])                   choice = 0;
            else                                choice = -1;

            chk("rnd imem_hready", 64'(imem_bus.hready), 64'(rdy[0]));
            chk("rnd dmem_hready", 64'(dmem_bus.hready), 64'(rdy[1]));
            chk("rnd imem_hresp", 64'(imem_bus.hresp), 64'(dp == 0 && mem_bus.hresp));
            chk("rnd dmem_hresp", 64'(dmem_bus.hresp), 64'(dp == 1 && mem_bus.hresp));
            chk("rnd dmem_hrdata", 64'(dmem_bus.hrdata), 64'(mem_bus.hrdata));
            chk("rnd hwdata", 64'(mem_bus.hwdata), 64'((dp < 0) ? 32'h0 : wdat[dp]));
            chk("rnd starve_cnt", 64'(dut.starve_cnt_q), 64'(starve));
            if (choice < 0) begin
                chk("rnd idle htrans", 64'(mem_bus.htrans), 64'(IDLE));
                chk("rnd idle haddr/hwrite", 64'({mem_bus.haddr, mem_bus.hwrite}), 64'(0));
            end else begin
                src = pend_v[choice] ? pend[choice] : cur[choice];
                chk("rnd htrans", 64'(mem_bus.htrans), 64'(NONSEQ));
                chk($sformatf("rnd request from m%0d", choice),
                    64'({mem_bus.haddr, mem_bus.hwrite, mem_bus.hsize, mem_bus.hburst, mem_bus.hmastlock, mem_bus.hprot}),
                    64'({src.addr, src.wr, src.sz, src.bu, src.ml, src.pr}));
            end

            if (reset) begin
                model_reset();
            end else begin
                if ((choice == 0 && mh) || !(cand[0] || busy[0])) starve = 0;
                else if (choice == 1 && mh && starve < LIMIT)     starve++;
                if (mh && dp >= 0) busy[dp] = 0;
                for (int m = 0; m < 2; m++) begin
                    if (live[m]) begin
                        busy[m] = 1;
                        wdat[m] = $urandom;
                    end
                    if (choice == m && mh) pend_v[m] = 0;
                    else if (live[m]) begin
                        pend_v[m] = 1;
                        pend[m]   = cur[m];
                    end
                    stay[m] = !rdy[m];
                end
                if (mh) dp = choice;
                frozen = (choice >= 0 && !mh) ? choice : -1;
            end
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
